// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: program/data RAM plus the memory-mapped I/O window
// (UART RX/TX, cycle counter, program stop) selected when mem_a[17:16] == 2'b11.
module mem_io_responder #(
   parameter int ADDR_WIDTH    = 17,
   parameter int TX_DEPTH_LOG2 = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_wdata,
   input  logic        mem_wr,
   output logic [7:0]  mem_rdata,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_stop,
   output logic        tx_overflow
);

   localparam int DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int PW    = TX_DEPTH_LOG2;
   localparam int CW    = TX_DEPTH_LOG2 + 1;

   logic [7:0]            ram [0:(1 << ADDR_WIDTH) - 1];
   logic [7:0]            ram_rdata_q;
   logic [7:0]            fifo_q [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  io_full_q, io_full_d;
   logic                  overflow_q, overflow_d;
   logic                  stop_req_q, stop_req_d;
   logic                  program_stop_q, program_stop_d;
   logic [31:0]           cycle_cnt_q, cycle_cnt_d;
   logic [31:0]           snap_q, snap_d;
   logic                  sel_io_q, sel_io_d;
   logic [7:0]            io_byte_q, io_byte_d;

   logic                  is_io;
   logic                  rd;
   logic                  uart_hit;
   logic                  cnt_hit;
   logic                  push_req;
   logic                  push;
   logic                  pop;
   logic [7:0]            io_rd_byte;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^mem_a[31:18];

   assign is_io    = (mem_a[17:16] == 2'b11);
   assign rd       = !mem_wr;
   assign uart_hit = is_io && (mem_a[15:0] == 16'h0000);
   assign cnt_hit  = is_io && (mem_a[15:2] == 14'h0001);
   assign ram_addr = mem_a[ADDR_WIDTH-1:0];

   always_ff @(posedge clk_in) begin
      if (mem_wr && !is_io) begin
         ram[ram_addr] <= mem_wdata;
      end
      if (rd && !is_io) begin
         ram_rdata_q <= ram[ram_addr];
      end
      if (push) begin
         fifo_q[wr_ptr_q] <= mem_wdata;
      end
   end

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      pop      = (count_q != '0) && tx_ready;
      push_req = mem_wr && uart_hit && (mem_wdata != 8'h00);
      push     = push_req && ((count_q != CW'(DEPTH)) || pop);

      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      io_full_d = (count_d >= CW'(DEPTH - 2));

      overflow_d     = overflow_q || (push_req && !push);
      stop_req_d     = stop_req_q || (mem_wr && cnt_hit && (mem_a[1:0] == 2'b00));
      program_stop_d = program_stop_q || (stop_req_q && (count_q == '0) && !push);
      cycle_cnt_d    = program_stop_q ? cycle_cnt_q : cycle_cnt_q + 32'd1;
   end

   // Byte 0 comes live from the counter while the same edge freezes the rest into the snapshot.
   always_comb begin
      io_rd_byte = 8'h00;
      snap_d     = snap_q;
      if (uart_hit) begin
         io_rd_byte = rx_valid ? rx_data : 8'h00;
      end else if (cnt_hit) begin
         unique case (mem_a[1:0])
            2'b00: io_rd_byte = cycle_cnt_q[7:0];
            2'b01: io_rd_byte = snap_q[15:8];
            2'b10: io_rd_byte = snap_q[23:16];
            2'b11: io_rd_byte = snap_q[31:24];
         endcase
         if (rd && (mem_a[1:0] == 2'b00)) begin
            snap_d = cycle_cnt_q;
         end
      end

      sel_io_d  = sel_io_q;
      io_byte_d = io_byte_q;
      if (rd) begin
         sel_io_d  = is_io;
         io_byte_d = io_rd_byte;
      end
   end

   // Reset selects the IO path with a zero byte, so mem_rdata reads 0 without clearing RAM.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         io_full_q      <= 1'b0;
         overflow_q     <= 1'b0;
         stop_req_q     <= 1'b0;
         program_stop_q <= 1'b0;
         cycle_cnt_q    <= '0;
         snap_q         <= '0;
         sel_io_q       <= 1'b1;
         io_byte_q      <= 8'h00;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         io_full_q      <= io_full_d;
         overflow_q     <= overflow_d;
         stop_req_q     <= stop_req_d;
         program_stop_q <= program_stop_d;
         cycle_cnt_q    <= cycle_cnt_d;
         snap_q         <= snap_d;
         sel_io_q       <= sel_io_d;
         io_byte_q      <= io_byte_d;
      end
   end

   assign mem_rdata      = sel_io_q ? io_byte_q : ram_rdata_q;
   assign io_buffer_full = io_full_q;
   assign tx_data        = fifo_q[rd_ptr_q];
   assign tx_valid       = (count_q != '0);
   assign rx_pop         = rst_in && rd && uart_hit && rx_valid;
   assign program_stop   = program_stop_q;
   assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/array reference model.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_wdata;
   logic        mem_wr;
   logic [7:0]  mem_rdata;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_stop;
   logic        tx_overflow;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   // Reference model state: FIFO as a queue, RAM as a sparse array.
   logic [7:0]  txQueue [$];
   logic [7:0]  ramModel [int];
   logic [7:0]  mRdata;
   bit          mKnown;
   bit          mOverflow;
   bit          mStopReq;
   bit          mStop;
   bit          mIoFull;
   logic [31:0] mCnt;
   logic [31:0] mSnap;

   mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH_LOG2(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wdata(mem_wdata),
      .mem_wr(mem_wr), .mem_rdata(mem_rdata), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_stop(program_stop), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      txQueue.delete();
      mRdata    = 8'h00;
      mKnown    = 1'b1;
      mOverflow = 1'b0;
      mStopReq  = 1'b0;
      mStop     = 1'b0;
      mIoFull   = 1'b0;
      mCnt      = 32'd0;
      mSnap     = 32'd0;
   endtask

   // One bus cycle as described by the protocol: decode, FIFO traffic, counter, read data.
   task automatic modelStep();
      logic [17:0] a;
      bit          io;
      int          key;
      int          sz;
      bit          pop;
      bit          pushReq;
      bit          accept;
      logic [31:0] oldCnt;
      a       = mem_a[17:0];
      io      = (a[17:16] == 2'b11);
      key     = int'(mem_a[16:0]);
      sz      = txQueue.size();
      pop     = (sz > 0) && tx_ready;
      pushReq = mem_wr && (a == 18'h30000) && (mem_wdata != 8'h00);
      accept  = pushReq && ((sz < 8) || pop);
      oldCnt  = mCnt;
      if (!mStop) mCnt = mCnt + 32'd1;
      if (mStopReq && sz == 0 && !pushReq) mStop = 1'b1;
      if (pop) void'(txQueue.pop_front());
      if (accept) txQueue.push_back(mem_wdata);
      if (pushReq && !accept) mOverflow = 1'b1;
      mIoFull = (txQueue.size() >= 6);
      if (mem_wr) begin
         if (!io) ramModel[key] = mem_wdata;
         else if (a == 18'h30004) mStopReq = 1'b1;
      end else begin
         mKnown = 1'b1;
         if (!io) begin
            if (ramModel.exists(key)) mRdata = ramModel[key];
            else mKnown = 1'b0;
         end else if (a == 18'h30000) begin
            mRdata = rx_valid ? rx_data : 8'h00;
         end else if (a == 18'h30004) begin
            mRdata = oldCnt[7:0];
            mSnap  = oldCnt;
         end else if (a >= 18'h30005 && a <= 18'h30007) begin
            mRdata = 8'(mSnap >> (8 * int'(a - 18'h30004)));
         end else begin
            mRdata = 8'h00;
         end
      end
   endtask

   // Model follows the DUT clock and reset, never the DUT outputs.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) modelReset();
      else modelStep();
   end

   task automatic checkOutput();
      logic expPop;
      expPop = rst_in && !mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid;
      if (mKnown) checkField("mem_rdata", {24'h0, mem_rdata}, {24'h0, mRdata});
      checkField("tx_valid", {31'h0, tx_valid}, {31'h0, txQueue.size() != 0});
      if (txQueue.size() != 0) checkField("tx_data", {24'h0, tx_data}, {24'h0, txQueue[0]});
      checkField("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, mIoFull});
      checkField("tx_overflow", {31'h0, tx_overflow}, {31'h0, mOverflow});
      checkField("program_stop", {31'h0, program_stop}, {31'h0, mStop});
      checkField("rx_pop", {31'h0, rx_pop}, {31'h0, expPop});
   endtask

   // Compare process: inputs change on the falling edge, outputs are sampled 2 ns later.
   always @(negedge clk_in) begin
      #2;
      if (checkEn) checkOutput();
   end

   task automatic setIdle(input logic txr);
      mem_a     = 32'h0003_0010;
      mem_wdata = 8'h00;
      mem_wr    = 1'b0;
      tx_ready  = txr;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [7:0] wd, input logic wr,
                                input logic txr, input logic rxv, input logic [7:0] rxd);
      @(negedge clk_in);
      mem_a     = a;
      mem_wdata = wd;
      mem_wr    = wr;
      tx_ready  = txr;
      rx_valid  = rxv;
      rx_data   = rxd;
   endtask

   task automatic idleCycle(input logic txr);
      applyStimulus(32'h0003_0010, 8'h00, 1'b0, txr, 1'b0, 8'h00);
   endtask

   task automatic doReset();
      @(negedge clk_in);
      rst_in = 1'b0;
      setIdle(1'b0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rnd;
      logic [1:0]  hi;
      int          op;
      bit          seen;

      setIdle(1'b0);
      rst_in  = 1'b0;
      checkEn = 1'b1;
      repeat (2) @(negedge clk_in);
      #1;
      checkField("reset_rdata", {24'h0, mem_rdata}, 32'h0);
      checkField("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      checkField("reset_io_full", {31'h0, io_buffer_full}, 32'h0);
      checkField("reset_stop", {31'h0, program_stop}, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;

      // RAM write then read-back one cycle later.
      applyStimulus(32'h0000_0100, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0000_0100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      idleCycle(1'b0);
      #1 checkField("ram_readback", {24'h0, mem_rdata}, 32'hA5);

      // UART RX read with and without a pending byte.
      applyStimulus(32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41);
      #1 checkField("rx_pop_pulse", {31'h0, rx_pop}, 32'h1);
      idleCycle(1'b0);
      #1 checkField("rx_pop_end", {31'h0, rx_pop}, 32'h0);
      checkField("rx_byte", {24'h0, mem_rdata}, 32'h41);
      applyStimulus(32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41);
      #1 checkField("rx_no_pop", {31'h0, rx_pop}, 32'h0);
      idleCycle(1'b0);
      #1 checkField("rx_empty_byte", {24'h0, mem_rdata}, 32'h0);

      // Fill the TX FIFO past capacity with the transmitter stalled.
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(32'h0003_0000, 8'(i), 1'b1, 1'b0, 1'b0, 8'h00);
         #1;
         if (i == 6) checkField("io_full_after5", {31'h0, io_buffer_full}, 32'h0);
         if (i == 7) checkField("io_full_after6", {31'h0, io_buffer_full}, 32'h1);
      end
      idleCycle(1'b0);
      #1 checkField("tx_overflow_set", {31'h0, tx_overflow}, 32'h1);
      for (int j = 1; j <= 8; j++) begin
         idleCycle(1'b1);
         #1 checkField("tx_drain_order", {24'h0, tx_data}, 32'(j));
      end
      idleCycle(1'b1);
      #1 checkField("tx_drained", {31'h0, tx_valid}, 32'h0);

      // Zero byte to the TX port is not transmitted.
      applyStimulus(32'h0003_0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
      idleCycle(1'b1);
      #1 checkField("tx_zero_ignored", {31'h0, tx_valid}, 32'h0);

      // Cycle counter: reading 0x30004 at cycle 1000 after reset yields a coherent 1000.
      doReset();
      repeat (999) idleCycle(1'b0);
      applyStimulus(32'h0003_0004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0003_0005, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      #1 checkField("cnt_byte0", {24'h0, mem_rdata}, 32'hE8);
      applyStimulus(32'h0003_0006, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      #1 checkField("cnt_byte1", {24'h0, mem_rdata}, 32'h03);
      applyStimulus(32'h0003_0007, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      #1 checkField("cnt_byte2", {24'h0, mem_rdata}, 32'h00);
      idleCycle(1'b0);
      #1 checkField("cnt_byte3", {24'h0, mem_rdata}, 32'h00);

      // Stop request waits for the TX FIFO to drain.
      applyStimulus(32'h0003_0000, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0003_0000, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0003_0000, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0003_0004, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
      repeat (3) begin
         idleCycle(1'b0);
         #1 checkField("stop_held", {31'h0, program_stop}, 32'h0);
      end
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         idleCycle(1'b1);
         #1 if (program_stop) seen = 1'b1;
      end
      checkField("stop_reached", {31'h0, seen}, 32'h1);
      repeat (5) idleCycle(1'b1);
      applyStimulus(32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      repeat (5) idleCycle(1'b1);
      applyStimulus(32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      idleCycle(1'b1);

      // Asynchronous reset in the middle of a cycle with bytes queued.
      applyStimulus(32'h0003_0000, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(32'h0003_0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99);
      #3 rst_in = 1'b0;
      #1;
      checkField("async_tx_valid", {31'h0, tx_valid}, 32'h0);
      checkField("async_stop", {31'h0, program_stop}, 32'h0);
      checkField("async_overflow", {31'h0, tx_overflow}, 32'h0);
      checkField("async_rdata", {24'h0, mem_rdata}, 32'h0);
      checkField("async_rx_pop", {31'h0, rx_pop}, 32'h0);
      @(negedge clk_in);
      setIdle(1'b0);
      @(negedge clk_in);
      rst_in = 1'b1;

      // Randomized traffic across RAM (including aliases), TX, RX, counter and unused IO.
      for (int n = 0; n < 2500; n++) begin
         rnd = $urandom();
         hi  = 2'($urandom_range(0, 2));
         op  = $urandom_range(0, 9);
         case (op)
            0, 1: applyStimulus({rnd[31:18], hi, 12'h010, rnd[3:0]}, 8'($urandom()), 1'b1,
                                rnd[10], rnd[11], 8'($urandom()));
            2, 3: applyStimulus({rnd[31:18], hi, 12'h010, rnd[3:0]}, 8'h00, 1'b0,
                                rnd[10], rnd[11], 8'($urandom()));
            4, 5: applyStimulus({rnd[31:18], 18'h30000}, rnd[13] ? 8'h00 : 8'($urandom()), 1'b1,
                                rnd[10], rnd[11], 8'($urandom()));
            6:    applyStimulus({rnd[31:18], 18'h30000}, 8'h00, 1'b0,
                                rnd[10], rnd[11], 8'($urandom()));
            7:    applyStimulus({rnd[31:18], 2'b11, 14'h0001, rnd[5:4]}, 8'h00, 1'b0,
                                rnd[10], rnd[11], 8'($urandom()));
            8:    applyStimulus({rnd[31:18], 2'b11, 8'h01, rnd[7:0]}, 8'($urandom()), rnd[12],
                                rnd[10], rnd[11], 8'($urandom()));
            default: idleCycle(rnd[10]);
         endcase
      end
      idleCycle(1'b1);
      @(negedge clk_in);
      #5;
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
